dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory between the CPU pipeline's load/store stage (LDUR/STUR) and the AES accelerator's DMA engine.
- CPU accesses are single-beat. AES accesses are locked bursts of 1–8 words.
- An aging counter stops either requester from starving the other.
- Sits between the execute/memory stage, the AES core and the data RAM.

Parameters:
- AW, 8, word-address width of data memory
- MAX_BURST, 8, maximum AES burst length in beats (power of two)
- STARVE_LIMIT, 4, consecutive cycles a pending AES request may lose to the CPU before AES gets priority

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cpu_v_i  in  1  CPU access request
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  AW  CPU word address
- cpu_wdata_i  in  16  CPU store data
- cpu_ready_o  out  1  CPU access accepted this cycle; pipeline stalls while cpu_v_i & ~cpu_ready_o
- cpu_rvalid_o  out  1  CPU load data valid
- cpu_rdata_o  out  16  CPU load data
- aes_v_i  in  1  AES beat valid
- aes_we_i  in  1  burst direction, sampled on first beat
- aes_addr_i  in  AW  burst base address, sampled on first beat
- aes_len_i  in  $clog2(MAX_BURST)  beats minus one, sampled on first beat
- aes_wdata_i  in  16  AES write data for the current beat
- aes_ready_o  out  1  AES beat accepted
- aes_rvalid_o  out  1  AES read data valid
- aes_rdata_o  out  16  AES read data
- aes_last_o  out  1  with aes_rvalid_o (read) or aes_ready_o (write): final beat of burst
- mem_en_o  out  1  memory access enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AW  memory word address
- mem_wdata_o  out  16  memory write data
- mem_rdata_i  in  16  memory read data, 1 cycle after mem_en_o & ~mem_we_o
- busy_o  out  1  AES burst in progress

Behaviour:
- Clocking: one clock, clk_i. reset_i is synchronous and active-high.
- Reset: state IDLE; beat counter, aging counter and read tags cleared. All outputs 0.
- States:
  - IDLE/CPU: single-beat owner is chosen each cycle.
  - AES_BURST: bus locked to AES.
- Arbitration in IDLE:
  - cpu_v_i and no AES starvation → grant CPU.
  - aes_v_i and (~cpu_v_i or aging counter == STARVE_LIMIT) → grant AES, capture base/len/we, issue beat 0, move to AES_BURST. If len == 0, stay IDLE and assert aes_last_o.
  - Granted CPU with aes_v_i pending → aging counter +1, saturating. Counter clears on any AES grant.
- CPU grant: in the same cycle, cpu_ready_o = 1 and mem_* driven combinationally from cpu_* inputs. 0-cycle arbitration latency.
- AES_BURST:
  - mem_addr_o = base + beat (mod 2^AW; wraps at the top of memory).
  - Beat issues only when aes_v_i = 1. If aes_v_i = 0 mid-burst, mem_en_o = 0, the counter holds and the bus stays locked.
  - On the last beat (beat == len): assert aes_last_o (writes), return to IDLE.
  - cpu_ready_o = 0 throughout. CPU stall ≤ MAX_BURST cycles when AES streams without gaps.
- Read return:
  - One-cycle tag register records {owner, is_last} for each issued read.
  - Next cycle, the owner's rvalid pulses with rdata = mem_rdata_i. aes_last_o pulses with the final AES read datum.
  - Writes produce no rvalid.
- Back-to-back: a new grant may issue in the cycle after a burst ends, including the cycle its last read data returns. The CPU and AES return paths are independent.
- Simultaneous events: cpu_v_i and aes_v_i together in IDLE with aging < STARVE_LIMIT → CPU wins, aging +1.
- Reset mid-burst: burst is abandoned, no further rvalid, state IDLE next cycle.
- Sampling: aes_we_i, aes_addr_i and aes_len_i are ignored after beat 0.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - owner enum {OWN_CPU, OWN_AES}
  - arbiter state enum {ARB_IDLE, ARB_AES_BURST}
  - DATA_W = 16
  - read-tag struct
- One natural sub-module: dmem_burst_counter (beat counter, address increment/wrap, last detection).

Test Plan:
- CPU store 0x1234 to addr 0x10, then load 0x10 → cpu_ready_o same cycle each time; cpu_rvalid_o one cycle after the load with 0x1234.
- AES 8-beat write from base 0xFC with data 0..7 → mem addresses FC, FD, FE, FF, 00, 01, 02, 03 (wrap); aes_last_o on beat 7; cpu_v_i held throughout sees cpu_ready_o = 0 for 8 cycles, then 1.
- cpu_v_i and aes_v_i asserted continuously from IDLE with STARVE_LIMIT = 4 → CPU granted 4 cycles, then AES burst granted on cycle 5; aging counter reads 0 after the grant.
- AES 4-beat read with aes_v_i dropped for 2 cycles after beat 1 → mem_en_o low for 2 cycles, addresses continue at base+2; 4 aes_rvalid_o pulses, last with aes_last_o.
- Single-beat AES read (len = 0) followed next cycle by a CPU load → both rvalids on consecutive cycles with correct data and no cross-routing.
- reset_i asserted during beat 2 of a read burst → all outputs 0 next cycle, no pending aes_rvalid_o; a new CPU request is accepted the cycle after reset deasserts.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types for the data-memory arbiter: bus owner, arbiter state and the
// read-return tag that follows each issued load by one cycle.
package cpu_mem_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_AES = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_IDLE      = 1'b0,
    ARB_AES_BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is_last;
  } rd_tag_t;

endpackage

// File: rtl/dmem_burst_counter.sv
// Beat counter for locked AES bursts: captures base/len/direction on beat 0,
// produces the wrapped beat address and flags the final beat.
module dmem_burst_counter
  import cpu_mem_pkg::*;
#(
  parameter int AW        = 8,
  parameter int MAX_BURST = 8,
  localparam int LW       = $clog2(MAX_BURST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          advance,
  input  logic          active,
  input  logic [AW-1:0] start_addr,
  input  logic [LW-1:0] start_len,
  input  logic          start_we,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic          we
);

  logic [LW-1:0] beat_q;
  logic [LW-1:0] len_q;
  logic [AW-1:0] base_q;
  logic          we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
    end else if (start) begin
      beat_q <= LW'(1);
    end else if (advance) begin
      beat_q <= last ? '0 : beat_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      base_q <= start_addr;
      len_q  <= start_len;
      we_q   <= start_we;
    end
  end

  // Outside a burst the counter passes beat-0 request fields straight through.
  assign addr = active ? AW'(base_q + AW'(beat_q)) : start_addr;
  assign last = active ? (beat_q == len_q) : (start_len == '0);
  assign we   = active ? we_q : start_we;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU load/store stage (single
// beats, zero-latency grant) and the AES DMA engine (locked 1..MAX_BURST bursts).
module dmem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW           = 8,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         cpu_v_i,
  input  logic                         cpu_we_i,
  input  logic [AW-1:0]                cpu_addr_i,
  input  logic [DATA_W-1:0]            cpu_wdata_i,
  output logic                         cpu_ready_o,
  output logic                         cpu_rvalid_o,
  output logic [DATA_W-1:0]            cpu_rdata_o,
  input  logic                         aes_v_i,
  input  logic                         aes_we_i,
  input  logic [AW-1:0]                aes_addr_i,
  input  logic [$clog2(MAX_BURST)-1:0] aes_len_i,
  input  logic [DATA_W-1:0]            aes_wdata_i,
  output logic                         aes_ready_o,
  output logic                         aes_rvalid_o,
  output logic [DATA_W-1:0]            aes_rdata_o,
  output logic                         aes_last_o,
  output logic                         mem_en_o,
  output logic                         mem_we_o,
  output logic [AW-1:0]                mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  input  logic [DATA_W-1:0]            mem_rdata_i,
  output logic                         busy_o
);

  localparam int GW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] age_q, age_d;
  rd_tag_t       tag_p0, tag_p1;

  logic          cpu_win;
  logic          aes_beat;
  logic          burst_start;
  logic          starved;
  logic [AW-1:0] bc_addr;
  logic          bc_last;
  logic          bc_we;

  function automatic logic [GW-1:0] age_sat_inc(input logic [GW-1:0] a);
    return (a == GW'(STARVE_LIMIT)) ? a : a + GW'(1);
  endfunction

  dmem_burst_counter #(
    .AW        (AW),
    .MAX_BURST (MAX_BURST)
  ) u_burst (
    .clk        (clk_i),
    .rst        (reset_i),
    .start      (burst_start),
    .advance    (aes_beat && (state_q == ARB_AES_BURST)),
    .active     (state_q == ARB_AES_BURST),
    .start_addr (aes_addr_i),
    .start_len  (aes_len_i),
    .start_we   (aes_we_i),
    .addr       (bc_addr),
    .last       (bc_last),
    .we         (bc_we)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ARB_IDLE;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    age_d       = age_q;
    cpu_win     = 1'b0;
    aes_beat    = 1'b0;
    burst_start = 1'b0;
    starved     = (age_q == GW'(STARVE_LIMIT));
    case (state_q)
      ARB_IDLE: begin
        if (aes_v_i && (!cpu_v_i || starved)) begin
          aes_beat = 1'b1;
          age_d    = '0;
          // A single-beat AES access completes here without locking the bus.
          if (aes_len_i != '0) begin
            burst_start = 1'b1;
            state_d     = ARB_AES_BURST;
          end
        end else if (cpu_v_i) begin
          cpu_win = 1'b1;
          if (aes_v_i) age_d = age_sat_inc(age_q);
        end
      end
      ARB_AES_BURST: begin
        if (aes_v_i) begin
          aes_beat = 1'b1;
          if (bc_last) state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Stage p0: memory command issue; every output is held low during reset.
  always_comb begin
    cpu_ready_o  = 1'b0;
    aes_ready_o  = 1'b0;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    cpu_rvalid_o = 1'b0;
    cpu_rdata_o  = '0;
    aes_rvalid_o = 1'b0;
    aes_rdata_o  = '0;
    aes_last_o   = 1'b0;
    busy_o       = 1'b0;
    if (!reset_i) begin
      if (cpu_win) begin
        cpu_ready_o = 1'b1;
        mem_en_o    = 1'b1;
        mem_we_o    = cpu_we_i;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
      end else if (aes_beat) begin
        aes_ready_o = 1'b1;
        mem_en_o    = 1'b1;
        mem_we_o    = bc_we;
        mem_addr_o  = bc_addr;
        mem_wdata_o = aes_wdata_i;
      end
      cpu_rvalid_o = tag_p1.valid && (tag_p1.owner == OWN_CPU);
      aes_rvalid_o = tag_p1.valid && (tag_p1.owner == OWN_AES);
      cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
      aes_rdata_o  = aes_rvalid_o ? mem_rdata_i : '0;
      aes_last_o   = (aes_beat && bc_we && bc_last) || (aes_rvalid_o && tag_p1.is_last);
      busy_o       = (state_q == ARB_AES_BURST);
    end
  end

  always_comb begin
    tag_p0.valid   = mem_en_o && !mem_we_o;
    tag_p0.owner   = aes_beat ? OWN_AES : OWN_CPU;
    tag_p0.is_last = aes_beat && bc_last;
  end

  // Stage p1: read-return tag, aligned with mem_rdata_i.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_p1 <= '0;
    end else begin
      tag_p1 <= tag_p0;
    end
  end

endmodule
